// File: rtl/ps2_rx_frame.sv
// ---------------------------------------------------------------------------
// ps2_rx_frame
// PS/2 device-to-host frame receiver. Synchronises and glitch-filters the raw
// PS/2 clock, samples data on filtered falling edges, deserialises 11-bit
// frames (start, 8 data LSB-first, odd parity, stop), checks parity, stop bit
// and inter-edge timeout, and queues good scancodes in a small FWFT FIFO.
//
// Ports
//   clk25      in   25 MHz system clock
//   rst        in   asynchronous, active-high reset
//   key_clk    in   raw PS/2 clock (asynchronous)
//   key_din    in   raw PS/2 data (asynchronous)
//   rd         in   pop request for the FIFO head
//   clr_ovf    in   clears the sticky overflow flag
//   code       out  FIFO head scancode, 8'h00 when empty
//   valid      out  FIFO non-empty
//   frame_err  out  one-cycle pulse on parity/stop error or timeout
//   overflow   out  sticky: a good frame was dropped on a full FIFO
//   busy       out  receiver FSM not in IDLE
//   state_dbg  out  receiver FSM state encoding, for observation only
//
// Handshake: code/valid present the FIFO head (first-word fall-through). The
// consumer reads code while valid=1 and asserts rd in that same cycle to pop
// it; the next entry (or 8'h00 / valid=0) appears on the following cycle.
// rd while valid=0 is ignored.
// ---------------------------------------------------------------------------
module ps2_rx_frame #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       key_clk,
  input  logic       key_din,
  input  logic       rd,
  input  logic       clr_ovf,
  output logic [7:0] code,
  output logic       valid,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Synchronisers: idle PS/2 lines are high, so reset to 1 to avoid a fake
  // falling edge coming out of reset.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   clk_s;
  logic                   din_s;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      clk_sync <= '1;
      din_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], key_clk};
      din_sync <= {din_sync[SYNC_STAGES-2:0], key_din};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign din_s = din_sync[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Clock glitch filter: a new level must persist FILTER_LEN cycles.
  // -------------------------------------------------------------------------
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          filt_take;
  logic          fall;

  assign filt_take = (clk_s != filt_clk) && (filt_cnt == FILT_MAX);
  // fall marks the cycle in which the filtered clock commits 1->0.
  assign fall      = filt_take && filt_clk;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_take) begin
      filt_clk <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Receiver FSM
  // -------------------------------------------------------------------------
  state_t        state, state_next;
  logic [2:0]    bitcnt, bitcnt_next;
  logic [7:0]    data, data_next;
  logic          par, par_next;
  logic [TW-1:0] to_cnt, to_next;
  logic          push;
  logic          err;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    bitcnt_next = bitcnt;
    data_next   = data;
    par_next    = par;
    to_next     = to_cnt;
    push        = 1'b0;
    err         = 1'b0;

    if (state == IDLE || fall) begin
      to_next = '0;
    end else begin
      to_next = to_cnt + TW'(1);
    end

    if (fall) begin
      case (state)
        IDLE: begin
          // A high data line on a fall is a spurious edge, not a start bit.
          if (!din_s) begin
            state_next  = DATA;
            bitcnt_next = 3'd0;
          end
        end
        DATA: begin
          data_next[bitcnt] = din_s;
          if (bitcnt == 3'd7) begin
            state_next = PARITY;
          end else begin
            bitcnt_next = bitcnt + 3'd1;
          end
        end
        PARITY: begin
          par_next   = din_s;
          state_next = STOP;
        end
        STOP: begin
          if ((^{data, par}) && din_s) begin
            push = 1'b1;
          end else begin
            err = 1'b1;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (state != IDLE && to_cnt == TO_MAX) begin
      state_next = IDLE;
      err        = 1'b1;
      to_next    = '0;
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      bitcnt    <= 3'd0;
      data      <= 8'h00;
      par       <= 1'b0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      bitcnt    <= bitcnt_next;
      data      <= data_next;
      par       <= par_next;
      to_cnt    <= to_next;
      frame_err <= err;
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // -------------------------------------------------------------------------
  // Scancode FIFO: pointers carry an extra wrap bit so full and empty are
  // distinguishable when the index bits match.
  // -------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = rd && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk25) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= data;
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Set has priority over clr_ovf so a drop coinciding with a clear is kept.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && full && !do_pop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign valid = !empty;
  assign code  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule
